pipe_stage_reg: RTL and testbench
=================================

# pipe_stage_reg

Parametrised, handshaked pipeline stage register for the five-stage MIPS core, replacing the fixed-field, always-capturing inter-stage registers. It carries an arbitrary data payload plus a control bundle between two stages, adds valid/ready flow control with a two-entry skid buffer so `in_ready` is a registered signal, and supports flush (bubble insertion) for branch/jump redirects. It also provides a saturating bubble counter for performance monitoring.

## Interface
Parameters:
- `DATA_W`, 32: payload width (operands, immediate, instruction, register indices packed by the instantiating stage).
- `CTRL_W`, 16: control bundle width (RegWrite, MemWrite, Branch, etc.); forced to zero on any bubble.
- `CNT_W`, 16: bubble counter width.

Ports:
- `clk`, in, 1: clock. State updates on the falling edge, matching the pipeline's register timing.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: upstream has a valid entry.
- `in_ready`, out, 1: stage can accept. Registered.
- `in_data`, in, DATA_W: upstream payload.
- `in_ctrl`, in, CTRL_W: upstream control bundle.
- `out_valid`, out, 1: head entry valid.
- `out_ready`, in, 1: downstream accepts the head entry.
- `out_data`, out, DATA_W: head payload.
- `out_ctrl`, out, CTRL_W: head control. All zeros whenever `out_valid`=0.
- `flush`, in, 1: discard all held entries and the incoming entry at this edge.
- `bubble_count`, out, CNT_W: saturating count of edges with `out_valid`=0.

## Operation
- Storage: main entry (M, drives outputs) and skid entry (S), each with a valid bit, data and ctrl.
- Transfers are evaluated at each falling edge:
  - push = `in_valid` & `in_ready`.
  - pop = `out_valid` & `out_ready`.
- No flush, by occupancy:
  - Empty: push loads M.
  - M only: with pop and push, M is replaced by the input. With pop only, M is cleared. With push only, the input goes to S.
  - M+S: `in_ready` is 0, so no push. Pop moves S into M and clears S.
- FIFO order is always preserved. S never holds an entry while M is empty.
- `in_ready` next = !(next S valid), i.e. 1 unless the stage will hold two entries after this edge.
- Flush has priority over push and pop:
  - M and S valid bits are cleared and their ctrl fields zeroed.
  - Data fields keep their old values.
  - Any concurrent push is dropped.
  - `in_ready` is 1 after the edge.
- `out_ctrl` = M.ctrl gated by M.valid, so a bubble never asserts write enables downstream.
- `bubble_count` increments at each edge where `out_valid`=0 before the edge. It saturates at 2^CNT_W−1 and does not wrap.
- Reset, applied asynchronously and taking effect immediately:
  - M and S valid = 0.
  - All data and ctrl fields = 0.
  - `in_ready` = 1.
  - `bubble_count` = 0.
  - This also holds when reset arrives mid-transfer. The first edge after release behaves as the empty state.

## Timing
- Latency: 1 edge from push into an empty stage to `out_valid`=1.
- Throughput: 1 entry per edge with `out_ready` held at 1. S stays unused.
- Stall, `out_ready`=0:
  - The first push after the stall begins lands in S.
  - `in_ready` falls right after that edge, so upstream sees it within one cycle with no combinational path from `out_ready`.
- Stall release from M+S:
  - Edge 1: S moves to M and `in_ready` rises.
  - Edge 2: a new push is accepted.
- Flush: outputs are invalid and ctrl is zero right after the flush edge. A push on the following edge is accepted normally.
- Flush, push and pop all on the same edge: the stage ends empty, and the popped head counts as consumed downstream.

## Test plan
- Reset mid-stream. Load 0xAAAA0001, assert `rst` between edges. Required: `out_valid`=0, `out_ctrl`=0, `out_data`=0, `in_ready`=1, `bubble_count`=0 immediately, before any clock edge.
- Streaming. Push 0x1, 0x2, 0x3 on consecutive edges with `out_ready`=1. Required: out sequence 0x1, 0x2, 0x3 on edges 1–3, each one edge after push, `in_ready` constantly 1.
- Stall/skid. `out_ready`=0, push 0x10 then 0x11. Required: `in_ready`=0 after the 2nd edge, and 0x12 held at input is not taken. Then `out_ready`=1: outputs 0x10, 0x11, 0x12 in order, nothing lost or duplicated.
- Flush with ctrl. M holds ctrl 0xFFFF and S holds an entry. Assert `flush` with `in_valid`=1 and data 0x99. Required: `out_valid`=0, `out_ctrl`=0x0000, `in_ready`=1 after the edge, and 0x99 never appears at the output.
- Bubble counter saturation. Use CNT_W=4 and an idle stage for 20 edges. Required: `bubble_count` reads 15 from edge 15 onward, and does not advance on edges where `out_valid`=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register with a two-entry skid buffer, flush-driven
// bubble insertion and a saturating bubble counter. State updates on the falling edge.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              m_valid_q, m_valid_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic              in_ready_q, in_ready_d;
  logic [CNT_W-1:0]  bubble_count_q, bubble_count_d;

  logic push;
  logic pop;

  assign push = in_valid & in_ready_q;
  assign pop  = m_valid_q & out_ready;

  always_comb begin
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    m_ctrl_d       = m_ctrl_q;
    s_valid_d      = s_valid_q;
    s_data_d       = s_data_q;
    s_ctrl_d       = s_ctrl_q;
    bubble_count_d = bubble_count_q;

    // Flush wins over push and pop; payload data is left stale on purpose.
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_ctrl_d  = '0;
      s_ctrl_d  = '0;
    end else if (!m_valid_q) begin
      if (push) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
        m_ctrl_d  = in_ctrl;
      end
    end else if (!s_valid_q) begin
      if (push && pop) begin
        m_data_d = in_data;
        m_ctrl_d = in_ctrl;
      end else if (pop) begin
        m_valid_d = 1'b0;
      end else if (push) begin
        s_valid_d = 1'b1;
        s_data_d  = in_data;
        s_ctrl_d  = in_ctrl;
      end
    end else if (pop) begin
      m_data_d  = s_data_q;
      m_ctrl_d  = s_ctrl_q;
      s_valid_d = 1'b0;
    end

    in_ready_d = !s_valid_d;

    if (!m_valid_q && (bubble_count_q != CNT_MAX)) begin
      bubble_count_d = bubble_count_q + CNT_W'(1);
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
      m_ctrl_q       <= '0;
      s_valid_q      <= 1'b0;
      s_data_q       <= '0;
      s_ctrl_q       <= '0;
      in_ready_q     <= 1'b1;
      bubble_count_q <= '0;
    end else begin
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
      m_ctrl_q       <= m_ctrl_d;
      s_valid_q      <= s_valid_d;
      s_data_q       <= s_data_d;
      s_ctrl_q       <= s_ctrl_d;
      in_ready_q     <= in_ready_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  // A bubble must never leak write enables downstream.
  assign out_valid    = m_valid_q;
  assign out_data     = m_data_q;
  assign out_ctrl     = m_ctrl_q & {CTRL_W{m_valid_q}};
  assign in_ready     = in_ready_q;
  assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed vectors push expected entries,
// a posedge monitor pops and compares whatever the stage hands downstream.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [15:0] in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_ctrl;
  logic        flush;
  logic [15:0] bubble_count;

  logic        sm_in_ready;
  logic        sm_out_valid;
  logic [31:0] sm_out_data;
  logic [15:0] sm_out_ctrl;
  logic [3:0]  sm_bubble_count;

  int checks   = 0;
  int failures = 0;
  logic [47:0] exp_q[$];

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .flush(flush), .bubble_count(bubble_count)
  );

  // Idle narrow-counter instance used for saturation.
  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst),
    .in_valid(1'b0), .in_ready(sm_in_ready), .in_data(32'h0), .in_ctrl(16'h0),
    .out_valid(sm_out_valid), .out_ready(1'b1), .out_data(sm_out_data), .out_ctrl(sm_out_ctrl),
    .flush(1'b0), .bubble_count(sm_bubble_count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Drive one edge worth of inputs; exp_rdy/acc are hand-derived for each vector.
  task automatic applyStimulus(input logic iv, input logic [31:0] d, input logic [15:0] c,
                               input logic ordy, input logic fl,
                               input logic exp_rdy, input logic acc);
    in_valid  = iv;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
    checkOutput("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
    if (acc) exp_q.push_back({c, d});
    @(negedge clk);
    #1;
    if (fl) exp_q.delete();
  endtask

  // Monitor: the head is consumed at the next falling edge when valid && ready.
  always @(posedge clk) begin
    if (!rst) begin
      if (!out_valid) begin
        checkOutput("bubble_ctrl", {16'b0, out_ctrl}, 32'h0);
      end else if (out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_out", out_data, 32'hDEAD_BEEF);
        end else begin
          logic [47:0] e;
          e = exp_q.pop_front();
          checkOutput("out_data", out_data, e[31:0]);
          checkOutput("out_ctrl", {16'b0, out_ctrl}, {16'b0, e[47:32]});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; in_valid = 0; in_data = 0; in_ctrl = 0; out_ready = 0; flush = 0;
    #2;
    checkOutput("rst_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("rst_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("rst_count", {16'b0, bubble_count}, 32'h0);
    checkOutput("rst_small_count", {28'b0, sm_bubble_count}, 32'h0);
    #1 rst = 1'b0;

    // Saturation on the small instance; main holds one entry for edges 2..4.
    for (int k = 1; k <= 20; k++) begin
      if (k == 1)      applyStimulus(1, 32'h20, 16'h0F0F, 0, 0, 1, 1);
      else if (k <= 4) applyStimulus(0, 32'h0, 16'h0, 0, 0, 1, 0);
      else             applyStimulus(0, 32'h0, 16'h0, 1, 0, 1, 0);
      checkOutput("small_count", {28'b0, sm_bubble_count}, (k < 15) ? k : 15);
      if (k == 4 || k == 5) checkOutput("count_hold", {16'b0, bubble_count}, 32'd1);
      if (k == 20)          checkOutput("count_after", {16'b0, bubble_count}, 32'd16);
    end

    // Streaming at full throughput.
    applyStimulus(1, 32'h1, 16'h0011, 1, 0, 1, 1);
    checkOutput("latency_valid", {31'b0, out_valid}, 32'h1);
    applyStimulus(1, 32'h2, 16'h0022, 1, 0, 1, 1);
    applyStimulus(1, 32'h3, 16'h0033, 1, 0, 1, 1);
    applyStimulus(0, 32'h0, 16'h0, 1, 0, 1, 0);
    checkOutput("stream_drained", {31'b0, out_valid}, 32'h0);

    // Stall and skid.
    applyStimulus(1, 32'h10, 16'h0100, 0, 0, 1, 1);
    applyStimulus(1, 32'h11, 16'h0101, 0, 0, 1, 1);
    applyStimulus(1, 32'h12, 16'h0102, 0, 0, 0, 0);
    applyStimulus(1, 32'h12, 16'h0102, 1, 0, 0, 0);
    applyStimulus(1, 32'h12, 16'h0102, 1, 0, 1, 1);
    applyStimulus(0, 32'h0, 16'h0, 1, 0, 1, 0);
    checkOutput("skid_empty", exp_q.size(), 32'h0);

    // Flush with both entries held and an incoming entry.
    applyStimulus(1, 32'h30, 16'hFFFF, 0, 0, 1, 1);
    applyStimulus(1, 32'h31, 16'h1234, 0, 0, 1, 1);
    applyStimulus(1, 32'h99, 16'h5555, 0, 1, 0, 0);
    checkOutput("flush_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("flush_ctrl", {16'b0, out_ctrl}, 32'h0);
    checkOutput("flush_ready", {31'b0, in_ready}, 32'h1);
    applyStimulus(1, 32'h40, 16'h00A5, 1, 0, 1, 1);
    applyStimulus(0, 32'h0, 16'h0, 1, 0, 1, 0);

    // Flush, push and pop on one edge: head consumed, push dropped.
    applyStimulus(1, 32'h50, 16'h0050, 1, 0, 1, 1);
    applyStimulus(1, 32'h51, 16'h0051, 1, 1, 1, 0);
    checkOutput("fpp_valid", {31'b0, out_valid}, 32'h0);
    applyStimulus(0, 32'h0, 16'h0, 1, 0, 1, 0);
    checkOutput("fpp_still_empty", {31'b0, out_valid}, 32'h0);

    // Reset mid-stream.
    applyStimulus(1, 32'hAAAA0001, 16'h00FF, 0, 0, 1, 1);
    checkOutput("pre_rst_valid", {31'b0, out_valid}, 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_valid", {31'b0, out_valid}, 32'h0);
    checkOutput("mid_rst_ctrl", {16'b0, out_ctrl}, 32'h0);
    checkOutput("mid_rst_data", out_data, 32'h0);
    checkOutput("mid_rst_ready", {31'b0, in_ready}, 32'h1);
    checkOutput("mid_rst_count", {16'b0, bubble_count}, 32'h0);
    exp_q.delete();
    #1 rst = 1'b0;
    applyStimulus(1, 32'h60, 16'h0060, 0, 0, 1, 1);
    checkOutput("post_rst_valid", {31'b0, out_valid}, 32'h1);
    checkOutput("post_rst_data", out_data, 32'h60);
    applyStimulus(0, 32'h0, 16'h0, 1, 0, 1, 0);

    checkOutput("final_queue_empty", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
